// File: rtl/ibex_register_file_mp.sv
// Multi-port flip-flop register file: N combinational read ports, M write
// ports with highest-index-wins arbitration, optional write-to-read bypass,
// optional dummy R0 register, a hardware clear sequencer and a sticky
// write-anomaly flag for the security alert path.
module ibex_register_file_mp #(
  parameter bit                   RV32E             = 1'b0,
  parameter int                   DataWidth         = 32,
  parameter int                   NumReadPorts      = 2,
  parameter int                   NumWritePorts     = 2,
  parameter bit                   WriteBypass       = 1'b0,
  parameter bit                   DummyInstructions = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal       = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              dummy_instr_id_i,
  input  logic [NumReadPorts*5-1:0]         raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  input  logic [NumWritePorts*5-1:0]        waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]          we_i,
  input  logic                              clear_req_i,
  output logic                              clear_busy_o,
  output logic                              err_o
);

  localparam int NumWords = RV32E ? 16 : 32;
  localparam int AddrW    = RV32E ? 4 : 5;
  localparam logic [AddrW-1:0] LastIdx = AddrW'(NumWords - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e               state_q;
  logic [AddrW-1:0]     cnt_q;
  logic                 err_q;
  logic                 err_d;
  // Word 0 doubles as the dummy R0 register; it is only ever read when
  // dummy instructions are enabled.
  logic [DataWidth-1:0] mem_q [NumWords];
  logic [NumWords-1:0]  wen;
  logic [DataWidth-1:0] wdat  [NumWords];

  // Per-word write decode; later (higher-index) ports override earlier ones.
  always_comb begin
    wen = '0;
    for (int a = 0; a < NumWords; a++) wdat[a] = WordZeroVal;
    for (int w = 0; w < NumWritePorts; w++) begin
      if (we_i[w] && !(RV32E && waddr_i[w*5+4])) begin
        if (waddr_i[w*5 +: 5] != 5'd0) begin
          wen[waddr_i[w*5 +: AddrW]]  = 1'b1;
          wdat[waddr_i[w*5 +: AddrW]] = wdata_i[w*DataWidth +: DataWidth];
        end else if (DummyInstructions && dummy_instr_id_i) begin
          wen[0]  = 1'b1;
          wdat[0] = wdata_i[w*DataWidth +: DataWidth];
        end
      end
    end
  end

  // Anomaly detection: out-of-range enabled writes and nonzero collisions, IDLE only.
  always_comb begin
    err_d = 1'b0;
    if (state_q == IDLE) begin
      for (int w = 0; w < NumWritePorts; w++) begin
        if (we_i[w] && RV32E && waddr_i[w*5+4]) err_d = 1'b1;
        for (int v = w + 1; v < NumWritePorts; v++) begin
          if (we_i[w] && we_i[v] && (waddr_i[w*5 +: 5] == waddr_i[v*5 +: 5]) &&
              (waddr_i[w*5 +: 5] != 5'd0) && !(RV32E && waddr_i[w*5+4])) begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  // Clear sequencer state, word counter and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_q | err_d;
      case (state_q)
        IDLE: begin
          if (clear_req_i) begin
            state_q <= CLEAR;
            cnt_q   <= AddrW'(1);
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + AddrW'(1);
          if (cnt_q == LastIdx) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage update: one word per edge while clearing, arbitrated writes otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int a = 0; a < NumWords; a++) mem_q[a] <= WordZeroVal;
    end else if (state_q == CLEAR) begin
      mem_q[cnt_q] <= WordZeroVal;
      if (cnt_q == AddrW'(1)) mem_q[0] <= WordZeroVal;
    end else begin
      for (int a = 0; a < NumWords; a++) begin
        if (wen[a]) mem_q[a] <= wdat[a];
      end
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    rdata_o = {NumReadPorts{WordZeroVal}};
    for (int p = 0; p < NumReadPorts; p++) begin
      if (raddr_i[p*5 +: 5] == 5'd0) begin
        if (DummyInstructions && dummy_instr_id_i) begin
          rdata_o[p*DataWidth +: DataWidth] =
            (WriteBypass && (state_q == IDLE) && wen[0]) ? wdat[0] : mem_q[0];
        end
      end else if (!(RV32E && raddr_i[p*5+4])) begin
        rdata_o[p*DataWidth +: DataWidth] =
          (WriteBypass && (state_q == IDLE) && wen[raddr_i[p*5 +: AddrW]]) ?
            wdat[raddr_i[p*5 +: AddrW]] : mem_q[raddr_i[p*5 +: AddrW]];
      end
    end
  end

  assign clear_busy_o = (state_q == CLEAR);
  assign err_o        = err_q;

endmodule
